fa_norm_round: RTL and testbench

- Final stage of the floating-point adder inside the MAC, parametrised by exponent and fraction width.
- Takes prefix-adder propagate/generate vectors and forms the sum. Then does carry-out handling, leading-one detection, normalisation shift, exponent adjust and round-to-nearest-even, and packs an IEEE-style result with exception flags.
- Sits between the prefix-carry network and the MAC accumulator register. Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/fa_norm_round.sv | 123 ++++++++++++
 tb/tb_fa_norm_round.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_norm_round.sv
// fa_norm_round: final FP-adder stage -- forms the sum from P/G, normalises, rounds to nearest-even and packs the result
// Ports:
//   CLK, RESETn                  clock, asynchronous active-low reset
//   in_valid/in_ready            input handshake (beat taken when both high)
//   in_sign, in_exp, in_add      sign and biased exponent of the larger operand, 1 = effective add
//   in_cin, P, G                 adder carry-in, propagate vector, per-bit carry-out vector
//   out_valid/out_ready          output handshake
//   out_result                   {sign, exp, frac}
//   out_ovf, out_unf, out_inx    overflow to infinity, underflow flushed to zero, inexact
module fa_norm_round #(
    parameter int EW = 8,
    parameter int MW = 23,
    localparam int W  = MW + 4,
    localparam int CW = $clog2(W + 1),
    localparam int XW = EW + 2
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EW-1:0]    in_exp,
    input  logic             in_add,
    input  logic             in_cin,
    input  logic [W-1:0]     P,
    input  logic [W-1:0]     G,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   out_result,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inx
);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

    logic adv1, adv2;
    logic [W-1:0] s;
    logic cout;
    logic [CW-1:0] lz;
    logic s1_valid, s1_cout, s1_sign, s1_add;
    logic [W-1:0] s1_s;
    logic [CW-1:0] s1_lz;
    logic [EW-1:0] s1_exp;
    logic [W-1:0] m;
    logic signed [XW-1:0] e_in, e, er;
    logic [W-3:0] mr;
    logic g, rs, up, zero, unf, ovf, inx;
    logic [EW+MW:0] res;

    assign adv2     = !out_valid | out_ready;
    assign adv1     = !s1_valid | adv2;
    assign in_ready = adv1;

    // G[i-1] is the carry into bit i; only an effective add may carry out of the top
    assign s    = P ^ {G[W-2:0], in_cin};
    assign cout = in_add & G[W-1];

    // highest set bit wins because the loop walks upward
    always_comb begin
        lz = CW'(W);
        for (int i = 0; i < W; i++)
            if (s[i]) lz = CW'(W - 1 - i);
    end

    always_comb begin
        e_in = $signed({2'b00, s1_exp});
        // a carry-out shifts right one place, folding the lost bit into sticky
        m    = s1_cout ? ({1'b1, s1_s[W-1:1]} | W'(s1_s[0])) : s1_s << s1_lz;
        e    = s1_cout ? e_in + XW'(1) : e_in - XW'(s1_lz);
        g    = m[2];
        rs   = m[1] | m[0];
        up   = g & (rs | m[3]);
        // mr[W-3] is the rounding carry; the fraction bits are then already zero
        mr   = {1'b0, m[W-1:3]} + (W-2)'(up);
        er   = e + XW'(mr[W-3]);
        zero = !s1_cout && s1_s == '0;
        unf  = !zero && !s1_cout && XW'(s1_lz) >= XW'(s1_exp);
        ovf  = !zero && !unf && (e >= EMAX || er >= EMAX);
        inx  = unf || ovf || (!zero && (g || rs));
        res  = zero ? {s1_add & s1_sign, (EW+MW)'(0)}
             : unf  ? {s1_sign, (EW+MW)'(0)}
             : ovf  ? {s1_sign, {EW{1'b1}}, MW'(0)}
             :        {s1_sign, er[EW-1:0], mr[MW-1:0]};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_valid   <= 1'b0;
            s1_cout    <= 1'b0;
            s1_sign    <= 1'b0;
            s1_add     <= 1'b0;
            s1_s       <= '0;
            s1_lz      <= '0;
            s1_exp     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_inx    <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_s    <= s;
                    s1_cout <= cout;
                    s1_lz   <= lz;
                    s1_sign <= in_sign;
                    s1_exp  <= in_exp;
                    s1_add  <= in_add;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= res;
                    out_ovf    <= ovf;
                    out_unf    <= unf;
                    out_inx    <= inx;
                end
            end
        end
    end
endmodule

// File: tb/tb_fa_norm_round.sv
// tb_fa_norm_round: self-checking bench for fa_norm_round against an arithmetic reference model
module tb_fa_norm_round;
    localparam int W = 27;

    logic CLK = 1'b0, RESETn = 1'b0;
    logic in_valid = 1'b0, in_ready, in_sign = 1'b0, in_add = 1'b0, in_cin = 1'b0;
    logic [7:0] in_exp = '0;
    logic [W-1:0] P = '0, G = '0;
    logic out_valid, out_ready = 1'b1;
    logic [31:0] out_result;
    logic out_ovf, out_unf, out_inx;
    logic [34:0] obs;
    int checks = 0, errors = 0;

    typedef struct {
        logic       sign;
        logic [7:0] exp;
        logic       add;
        logic [26:0] a;
        logic [26:0] b;
    } beat_t;

    fa_norm_round dut (
        .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_add(in_add), .in_cin(in_cin),
        .P(P), .G(G), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf), .out_inx(out_inx)
    );

    assign obs = {out_result, out_ovf, out_unf, out_inx};

    always #5 CLK = ~CLK;

    // Upstream adder view: B is inverted with carry-in 1 for subtraction, G is the ripple carry out of each bit
    task automatic drive(beat_t b);
        logic [26:0] bx;
        logic c;
        bx = b.add ? b.b : ~b.b;
        c = !b.add;
        in_sign = b.sign;
        in_exp = b.exp;
        in_add = b.add;
        in_cin = c;
        for (int i = 0; i < W; i++) begin
            P[i] = b.a[i] ^ bx[i];
            G[i] = (b.a[i] & bx[i]) | (P[i] & c);
            c = G[i];
        end
    endtask

    // Reference: true sum/difference, normalise to the hidden bit, round to nearest-even; {result, ovf, unf, inx}
    function automatic logic [34:0] model(beat_t b);
        longint v, m, keep;
        int p, e;
        logic gb, rsb;
        v = b.add ? longint'(b.a) + longint'(b.b) : longint'(b.a) - longint'(b.b);
        if (v == 0) return {b.add & b.sign, 34'b0};
        p = 27;
        while (((v >> p) & 1) == 0) p--;
        e = int'(b.exp) + p - 26;
        if (e <= 0) return {b.sign, 31'b0, 3'b011};
        m = (p == 27) ? ((v >> 1) | (v & 1)) : (v << (26 - p));
        gb = m[2];
        rsb = m[1] | m[0];
        keep = (m >> 3) + longint'(gb & (rsb | m[3]));
        if (keep == (longint'(1) << 24)) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {b.sign, 8'hFF, 23'b0, 3'b101};
        return {b.sign, 8'(e), 23'(keep), 2'b00, gb | rsb};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        logic [26:0] d;
        int r;
        b.sign = 1'($urandom);
        b.add = 1'($urandom);
        r = $urandom % 8;
        b.exp = (r == 0) ? 8'($urandom_range(1, 30)) : (r == 1) ? 8'($urandom_range(250, 254)) : 8'($urandom_range(1, 254));
        b.a = {1'b1, 26'($urandom)};
        d = 27'($urandom) >> $urandom_range(0, 26);
        if (b.add)
            b.b = ($urandom % 2 == 0) ? {1'b1, 26'($urandom)} : d;
        else begin
            if (d > b.a) d = b.a;
            b.b = b.a - d;
        end
        return b;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || obs !== 35'b0) begin
            errors++;
            $display("FAIL reset_active: got valid=%b out=%h expected valid=0 out=0", out_valid, obs);
        end
        RESETn = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || obs !== 35'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b ready=%b out=%h expected valid=0 ready=1 out=0", out_valid, in_ready, obs);
        end
    endtask

    task automatic test_directed();
        beat_t v[9];
        logic [34:0] x[9];
        v[0] = '{1'b0, 8'd127, 1'b1, 27'h4000000, 27'h4000000}; x[0] = {32'h40000000, 3'b000};
        v[1] = '{1'b0, 8'd127, 1'b0, 27'h4000000, 27'h3FFFFF8}; x[1] = {32'h34000000, 3'b000};
        v[2] = '{1'b1, 8'd127, 1'b0, 27'h5555558, 27'h5555558}; x[2] = {32'h00000000, 3'b000};
        v[3] = '{1'b0, 8'd127, 1'b1, 27'h4000000, 27'h0000004}; x[3] = {32'h3F800000, 3'b001};
        v[4] = '{1'b0, 8'd127, 1'b1, 27'h4000000, 27'h000000C}; x[4] = {32'h3F800002, 3'b001};
        v[5] = '{1'b0, 8'd254, 1'b1, 27'h4000000, 27'h4000000}; x[5] = {32'h7F800000, 3'b101};
        v[6] = '{1'b0, 8'd3,   1'b0, 27'h4000000, 27'h3FF0000}; x[6] = {32'h00000000, 3'b011};
        v[7] = '{1'b1, 8'd127, 1'b0, 27'h4000000, 27'h2000000}; x[7] = {32'hBF000000, 3'b000};
        v[8] = '{1'b1, 8'd127, 1'b1, 27'h0000000, 27'h0000000}; x[8] = {32'h80000000, 3'b000};
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(v[k]);
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready: got %b expected 1", k, in_ready);
            end
            @(negedge CLK);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_early: got out_valid=%b expected 0 after one cycle", k, out_valid);
            end
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b1 || obs !== x[k]) begin
                errors++;
                $display("FAIL dir%0d_result: got valid=%b out=%h expected valid=1 out=%h", k, out_valid, obs, x[k]);
            end
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dir_no_dup: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:11] rp = 12'b111001111111;
        logic [34:0] q[$], held, ex;
        logic held_valid = 1'b0;
        beat_t bs[4];
        int sent = 0, got = 0;
        for (int k = 0; k < 4; k++) bs[k] = rand_beat();
        for (int c = 0; c < 40 && got < 4; c++) begin
            out_ready = (c < 12) ? rp[c] : 1'b1;
            in_valid = sent < 4;
            if (sent < 4) drive(bs[sent]);
            #1;
            checks++;
            if (in_ready !== !(q.size() == 2 && !out_ready)) begin
                errors++;
                $display("FAIL b2b_in_ready c%0d: got %b expected %b", c, in_ready, !(q.size() == 2 && !out_ready));
            end
            if (held_valid) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    errors++;
                    $display("FAIL b2b_stall_hold c%0d: got valid=%b out=%h expected valid=1 out=%h", c, out_valid, obs, held);
                end
            end
            held_valid = out_valid && !out_ready;
            held = obs;
            if (out_valid && out_ready) begin
                checks++;
                got++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious c%0d: got out=%h expected no output", c, obs);
                end else begin
                    ex = q.pop_front();
                    if (obs !== ex) begin
                        errors++;
                        $display("FAIL b2b_result c%0d: got %h expected %h", c, obs, ex);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(bs[sent]));
                sent++;
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 4 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs, %0d pending expected 4 outputs, 0 pending", got, q.size());
        end
    endtask

    task automatic test_random();
        logic [34:0] q[$], ex;
        beat_t b;
        int sent = 0, got = 0;
        b = rand_beat();
        for (int c = 0; c < 4000 && got < 300; c++) begin
            out_ready = ($urandom % 10) < 7;
            in_valid = sent < 300 && ($urandom % 4) != 0;
            drive(b);
            #1;
            checks++;
            if (in_ready !== !(q.size() == 2 && !out_ready)) begin
                errors++;
                $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, in_ready, !(q.size() == 2 && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                got++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious c%0d: got out=%h expected no output", c, obs);
                end else begin
                    ex = q.pop_front();
                    if (obs !== ex) begin
                        errors++;
                        $display("FAIL rnd_result c%0d: got %h expected %h", c, obs, ex);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(b));
                sent++;
                b = rand_beat();
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 300) begin
            errors++;
            $display("FAIL rnd_count: got %0d outputs expected 300", got);
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0;
        drive(rand_beat());
        in_valid = 1'b1;
        @(negedge CLK);
        drive(rand_beat());
        @(negedge CLK);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight_setup: got out_valid=%b expected 1", out_valid);
        end
        RESETn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs !== 35'b0) begin
            errors++;
            $display("FAIL inflight_async_clear: got valid=%b out=%h expected valid=0 out=0", out_valid, obs);
        end
        @(negedge CLK);
        RESETn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_dropped c%0d: got out_valid=%b expected 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
